gas_pump_metered_ctrl: RTL
==========================

Name: gas_pump_metered_ctrl

Overview:
Metered, pre-authorised single-nozzle fuel pump controller built as a Moore FSM. It extends the basic nozzle/pressure pump controller with a preset volume limit, a volume meter (clock-divided dispense units), an idle timeout, a pause/resume state and a latched completion reason. It sits between the payment/authorisation logic and the pump valve driver.

Parameters:
VOL_W, 8, width of the preset and metered volume (units).
PULSE_DIV, 4, clk cycles of active pumping per volume unit (>=1).
TIMEOUT_CYC, 8, max cycles allowed in AUTH or PAUSE before abort (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
authorize  input  1  start request; sampled only in IDLE.
preset_vol  input  VOL_W  volume limit; latched when authorize is accepted.
nozzleSwitch  input  1  1 = nozzle trigger pulled.
pressureSensor  input  1  1 = tank-full back-pressure.
fuel_out  output  1  valve open; 1 only in PUMP.
volume_out  output  VOL_W  units dispensed this transaction.
done  output  1  high exactly while in DONE (one cycle).
done_reason  output  2  0 = limit reached, 1 = tank full, 2 = timeout, 3 = unused.
State_out  output  3  current state encoding.

Behaviour:
- Reset (reset=0, async): state IDLE, fuel_out=0, volume_out=0, done=0, done_reason=0, div/timeout counters=0, latched preset=0. Reset mid-pump closes the valve immediately.
- Encoding: IDLE=0, AUTH=1, PUMP=2, PAUSE=3, DONE=4; 5-7 are illegal and go to IDLE next edge.
- Moore outputs: fuel_out, done and State_out decode from the state register only. Every input effect appears one clk edge later.
- IDLE:
  - authorize=1 and preset_vol!=0 -> AUTH; latch preset, clear volume_out and timeout counter.
  - authorize with preset_vol=0 is ignored.
  - volume_out and done_reason hold their last values.
- AUTH:
  - nozzleSwitch=1 and pressureSensor=0 -> PUMP, with div counter cleared.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC-1 -> DONE with reason 2.
  - The exit-to-PUMP condition beats timeout on the same edge.
- PUMP:
  - div counter increments each cycle. At PULSE_DIV-1 it wraps to 0 and volume_out increments.
  - Transition priority on each edge:
    (1) pressureSensor=1 -> DONE, reason 1.
    (2) volume increment making volume_out == preset -> DONE, reason 0.
    (3) nozzleSwitch=0 -> PAUSE; timeout counter cleared, div counter held.
  - The volume increment is still applied on an edge where (1) or (3) fires.
  - An uninterrupted fill is exactly preset*PULSE_DIV cycles of fuel_out=1.
  - volume_out never exceeds preset, so there is no overflow.
- PAUSE:
  - pressureSensor=1 -> DONE, reason 1.
  - Else nozzleSwitch=1 -> PUMP, div counter resumes from its held value.
  - Else timeout as in AUTH -> DONE, reason 2.
- DONE: one cycle, then IDLE unconditionally. authorize is ignored in every state except IDLE.

Test Plan:
- Reset, authorize with preset=3, nozzle=1, pressure=0 held -> State_out 0→1→2; fuel_out=1 for exactly 12 cycles; volume_out counts 1,2,3 every 4 cycles; then State_out=4, done=1 for 1 cycle, done_reason=0, then IDLE with volume_out=3 held.
- preset=5, pump 6 cycles, nozzle=0 for 3 cycles, nozzle=1 -> PAUSE for 3 cycles with fuel_out=0 and volume_out=1 frozen. On resume, div continues from 2. Completion occurs at a total of 20 PUMP cycles, reason 0.
- preset=10, pressure=1 after 9 PUMP cycles -> next edge DONE, fuel_out=0, volume_out=2, done_reason=1.
- authorize with preset=4 and no nozzle -> 8 cycles in AUTH, then DONE, done_reason=2, volume_out=0. Repeat with nozzle=0 in PAUSE -> same timeout, reason 2.
- preset=0 with authorize -> stays IDLE. authorize pulsed during PUMP -> ignored, preset unchanged.
- Assert reset=0 asynchronously mid-PUMP (between clock edges) -> fuel_out=0 and State_out=0 immediately; after release, the next transaction starts with volume_out cleared on accept.

Source files
------------

// File: rtl/gas_pump_metered_ctrl_if.sv
// Bus between the payment/authorisation side and the metered pump controller.
// master: drives the authorisation request, preset volume and the nozzle and
//         pressure sensors, and observes the valve, meter and completion status.
// slave : the pump controller.
// Signals: authorize, preset_vol[VOL_W], nozzleSwitch, pressureSensor (to controller);
//          fuel_out, volume_out[VOL_W], done, done_reason[2], State_out[3] (from controller).
interface gas_pump_metered_ctrl_if #(
    parameter int VOL_W = 8
);
    logic             authorize;
    logic [VOL_W-1:0] preset_vol;
    logic             nozzleSwitch;
    logic             pressureSensor;
    logic             fuel_out;
    logic [VOL_W-1:0] volume_out;
    logic             done;
    logic [1:0]       done_reason;
    logic [2:0]       State_out;

    modport master (
        output authorize, preset_vol, nozzleSwitch, pressureSensor,
        input  fuel_out, volume_out, done, done_reason, State_out
    );

    modport slave (
        input  authorize, preset_vol, nozzleSwitch, pressureSensor,
        output fuel_out, volume_out, done, done_reason, State_out
    );
endinterface

// File: rtl/gas_pump_metered_ctrl.sv
// Metered, pre-authorised single-nozzle fuel pump controller (Moore FSM).
// A transaction is accepted in IDLE with a non-zero preset volume, waits in AUTH
// for the trigger, dispenses in PUMP (one volume unit per PULSE_DIV active
// cycles), may pause while the trigger is released, and ends in a one-cycle DONE
// carrying the reason: 0 = limit reached, 1 = tank full, 2 = timeout.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of gas_pump_metered_ctrl_if (inputs, valve, meter, status)
module gas_pump_metered_ctrl #(
    parameter int VOL_W       = 8,
    parameter int PULSE_DIV   = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    gas_pump_metered_ctrl_if.slave bus
);
    localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PULSE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AUTH  = 3'd1,
        PUMP  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [VOL_W-1:0] preset_q;
    logic [VOL_W-1:0] volume_q;
    logic [1:0]       reason_q;
    logic [DIV_W-1:0] div_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    // Meter arithmetic for the current PUMP cycle: a unit is credited on the
    // cycle the divider wraps, and the fill is complete when that credit
    // brings the meter up to the latched preset.
    logic             div_wrap;
    logic [VOL_W-1:0] vol_inc;
    logic             hit_limit;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign vol_inc   = volume_q + VOL_W'(1);
    assign hit_limit = div_wrap && (vol_inc == preset_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            preset_q <= '0;
            volume_q <= '0;
            reason_q <= 2'd0;
            div_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.authorize && (bus.preset_vol != '0)) begin
                        state    <= AUTH;
                        preset_q <= bus.preset_vol;
                        volume_q <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                AUTH: begin
                    // Trigger pulled wins over a timeout expiring on the same edge.
                    if (bus.nozzleSwitch && !bus.pressureSensor) begin
                        state   <= PUMP;
                        div_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= DONE;
                        reason_q <= 2'd2;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                PUMP: begin
                    // Metering advances on every PUMP cycle, including the one
                    // that leaves PUMP; the divider is left where it is on a
                    // pause so the partial unit carries over.
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) begin
                        volume_q <= vol_inc;
                    end
                    if (bus.pressureSensor) begin
                        state    <= DONE;
                        reason_q <= 2'd1;
                    end else if (hit_limit) begin
                        state    <= DONE;
                        reason_q <= 2'd0;
                    end else if (!bus.nozzleSwitch) begin
                        state   <= PAUSE;
                        tmo_cnt <= '0;
                    end
                end
                PAUSE: begin
                    if (bus.pressureSensor) begin
                        state    <= DONE;
                        reason_q <= 2'd1;
                    end else if (bus.nozzleSwitch) begin
                        state <= PUMP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= DONE;
                        reason_q <= 2'd2;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs decode from the state register only, so an asynchronous
    // reset closes the valve without waiting for a clock edge.
    assign bus.fuel_out    = (state == PUMP);
    assign bus.done        = (state == DONE);
    assign bus.State_out   = state;
    assign bus.volume_out  = volume_q;
    assign bus.done_reason = reason_q;
endmodule
